token_feeder: RTL and testbench

Upstream stage of the `stack` expression evaluator. It buffers 7-bit tokens from a producer (pattern ROM, UART decoder) in a small synchronous FIFO. It then delivers them one at a time on the evaluator's `req`/`en`/`variable` handshake, so the evaluator never sees a token it did not request. It decouples producer burstiness from evaluator stalls and enforces the evaluator's one-cycle `en` pulse rule.

---
 rtl/stack_pkg.sv | 29 ++
 rtl/token_feeder_sync_fifo.sv | 70 +++++++
 rtl/token_feeder.sv | 89 ++++++++
 tb/tb_token_feeder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack expression evaluator, its token feeder
// and the benches that drive them.
package stack_pkg;

    localparam int unsigned TOKEN_W  = 7;
    localparam int unsigned ANSWER_W = 10;

    // Token codes agreed between producer, feeder and evaluator.
    // The feeder treats every code as opaque data.
    localparam logic [TOKEN_W-1:0] TOK_DIGIT_BASE = 7'h30; // '0'..'9' follow
    localparam logic [TOKEN_W-1:0] TOK_ADD        = 7'h2B;
    localparam logic [TOKEN_W-1:0] TOK_SUB        = 7'h2D;
    localparam logic [TOKEN_W-1:0] TOK_MUL        = 7'h2A;
    localparam logic [TOKEN_W-1:0] TOK_LPAREN     = 7'h28;
    localparam logic [TOKEN_W-1:0] TOK_RPAREN     = 7'h29;
    localparam logic [TOKEN_W-1:0] TOK_END        = 7'h3D;

    // Issue FSM of the token feeder
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } feed_state_t;

    // True when a token code is one of the ten digit codes
    function automatic logic is_digit(input logic [TOKEN_W-1:0] tok);
        return (tok >= TOK_DIGIT_BASE) && (tok <= TOK_DIGIT_BASE + 7'd9);
    endfunction

endpackage

// File: rtl/token_feeder_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pointers wrap
// naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify requests so a full/empty FIFO can never be corrupted
    always_comb begin
        w_do_push = push && (r_level != LVL_FULL);
        w_do_pop  = pop  && (r_level != '0);
    end

    // Storage: contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Head of queue and status flags from registered state only
    always_comb begin
        rdata = r_mem[r_rd_ptr];
        level = r_level;
        full  = (r_level == LVL_FULL);
        empty = (r_level == '0);
    end

endmodule

// File: rtl/token_feeder.sv
// Buffers producer tokens and hands them to the evaluator one at a time
// as single-cycle en pulses, only while the evaluator requests them.
module token_feeder
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [TOKEN_W-1:0]  in_data,
    output logic                in_ready,
    input  logic                req,
    output logic                en,
    output logic [TOKEN_W-1:0]  variable,
    output logic [AW:0]         level
);

    feed_state_t        r_state;
    logic               r_en;
    logic [TOKEN_W-1:0] r_variable;

    logic               w_push;
    logic               w_pop;
    logic [TOKEN_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic [AW:0]        w_level;

    // Handshake qualification: pop only from IDLE with a buffered token
    always_comb begin
        w_push = in_valid && !w_full;
        w_pop  = (r_state == ST_IDLE) && req && !w_empty;
    end

    sync_fifo #(
        .WIDTH (TOKEN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_head),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    // Issue FSM with registered en/variable; ISSUE always lasts one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_variable <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_ISSUE;
                        r_en       <= 1'b1;
                        r_variable <= w_head;
                    end
                end
                ST_ISSUE: begin
                    r_state    <= ST_IDLE;
                    r_en       <= 1'b0;
                    r_variable <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_en       <= 1'b0;
                    r_variable <= '0;
                end
            endcase
        end
    end

    // Output wiring
    always_comb begin
        en       = r_en;
        variable = r_variable;
        level    = w_level;
        in_ready = !w_full;
    end

endmodule

// File: tb/tb_token_feeder.sv
// Directed self-checking bench for token_feeder.
module tb_token_feeder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic       req;
    logic       en;
    logic [6:0] variable;
    logic [4:0] level;

    int tests_run;
    int tests_failed;

    token_feeder #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .req      (req),
        .en       (en),
        .variable (variable),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        req      = 1'b0;
        #3;
        tests_run++;
        if (en !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %b expected 0", en); end
        tests_run++;
        if (variable !== 7'h00) begin tests_failed++; $display("FAIL reset_variable: got %h expected 00", variable); end
        tests_run++;
        if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
        tick();
        rst = 1'b1;
        req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if (en !== 1'b0 || variable !== 7'h00) begin
                tests_failed++;
                $display("FAIL empty_req cycle %0d: got en=%b var=%h expected en=0 var=00", i, en, variable);
            end
        end
        tests_run++;
        if (level !== 5'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_req_status: got level=%0d ready=%b expected level=0 ready=1", level, in_ready);
        end
    endtask

    task automatic test_single();
        req      = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'h2A;
        tick();                     // edge N: push
        in_valid = 1'b0;
        tests_run++;
        if (en !== 1'b0 || level !== 5'd1) begin
            tests_failed++;
            $display("FAIL single_edgeN: got en=%b level=%0d expected en=0 level=1", en, level);
        end
        tick();                     // edge N+1: issue
        tests_run++;
        if (en !== 1'b1 || variable !== 7'h2A || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL single_issue: got en=%b var=%h level=%0d expected en=1 var=2a level=0", en, variable, level);
        end
        tick();                     // edge N+2: pulse ends
        tests_run++;
        if (en !== 1'b0 || variable !== 7'h00) begin
            tests_failed++;
            $display("FAIL single_end: got en=%b var=%h expected en=0 var=00", en, variable);
        end
        req = 1'b0;
        tick();
    endtask

    task automatic test_fill_wrap();
        logic [6:0] exp_q [$];
        int         last_en_cyc;
        int         got;
        logic       acc;
        req = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 7'(i);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 7'h7F;
        tests_run++;
        if (level !== 5'd16 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: got level=%0d ready=%b expected level=16 ready=0", level, in_ready);
        end
        tick();
        tick();
        tests_run++;
        if (level !== 5'd16 || en !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_hold: got level=%0d en=%b expected level=16 en=0", level, en);
        end
        for (int i = 1; i <= 16; i++) exp_q.push_back(7'(i));
        exp_q.push_back(7'h7F);
        req = 1'b1;
        last_en_cyc = -1;
        got = 0;
        for (int c = 0; c < 80 && got < 17; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            if (en === 1'b1) begin
                tests_run++;
                if (variable !== exp_q[got]) begin
                    tests_failed++;
                    $display("FAIL fill_order idx %0d: got %h expected %h", got, variable, exp_q[got]);
                end
                if (last_en_cyc >= 0) begin
                    tests_run++;
                    if (c - last_en_cyc != 2) begin
                        tests_failed++;
                        $display("FAIL fill_spacing idx %0d: got gap %0d expected 2", got, c - last_en_cyc);
                    end
                end
                last_en_cyc = c;
                got++;
            end
        end
        tests_run++;
        if (got != 17) begin
            tests_failed++;
            $display("FAIL fill_count: got %0d tokens expected 17", got);
        end
        tick();
        tests_run++;
        if (level !== 5'd0 || en !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_drained: got level=%0d en=%b expected level=0 en=0", level, en);
        end
        req = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [6:0] exp_q [$];
        logic [6:0] d;
        logic       acc;
        logic       prev_en;
        int         pushed;
        int         popped;
        int         bad;
        d = 7'h00;
        prev_en = 1'b0;
        pushed = 0;
        popped = 0;
        bad = 0;
        in_valid = 1'b1;
        in_data = d;
        for (int c = 0; c < 3000; c++) begin
            req = ($urandom_range(0, 3) != 0);
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(in_data);
            tick();
            if (acc) begin
                d = d + 7'd1;
                in_data = d;
                pushed++;
            end
            if (en === 1'b1) begin
                if (prev_en === 1'b1) bad++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stream_unexpected: got %h expected no token", variable);
                end else begin
                    if (variable !== exp_q[0]) begin
                        tests_failed++;
                        $display("FAIL stream_data idx %0d: got %h expected %h", popped, variable, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                popped++;
            end else if (variable !== 7'h00) begin
                bad++;
            end
            prev_en = en;
        end
        in_valid = 1'b0;
        req = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            tick();
            if (en === 1'b1) begin
                if (prev_en === 1'b1) bad++;
                tests_run++;
                if (variable !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL stream_drain idx %0d: got %h expected %h", popped, variable, exp_q[0]);
                end
                void'(exp_q.pop_front());
                popped++;
            end
            prev_en = en;
        end
        tests_run++;
        if (exp_q.size() != 0 || popped != pushed) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d delivered expected %0d", popped, pushed);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stream_protocol: got %0d violations expected 0", bad);
        end
        tick();
        req = 1'b0;
        tick();
    endtask

    task automatic test_req_drop();
        int extra;
        req = 1'b0;
        in_valid = 1'b1;
        in_data = 7'h11;
        tick();
        in_data = 7'h22;
        tick();
        in_valid = 1'b0;
        req = 1'b1;
        tick();
        tests_run++;
        if (en !== 1'b1 || variable !== 7'h11) begin
            tests_failed++;
            $display("FAIL drop_first: got en=%b var=%h expected en=1 var=11", en, variable);
        end
        req = 1'b0;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (en !== 1'b0) extra++;
        end
        tests_run++;
        if (extra != 0 || level !== 5'd1) begin
            tests_failed++;
            $display("FAIL drop_hold: got %0d pulses level=%0d expected 0 pulses level=1", extra, level);
        end
        req = 1'b1;
        tick();
        tests_run++;
        if (en !== 1'b1 || variable !== 7'h22) begin
            tests_failed++;
            $display("FAIL drop_resume: got en=%b var=%h expected en=1 var=22", en, variable);
        end
        req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        int extra;
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 7'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        req = 1'b1;
        tick();
        tests_run++;
        if (en !== 1'b1 || variable !== 7'h40 || level !== 5'd4) begin
            tests_failed++;
            $display("FAIL arst_pre: got en=%b var=%h level=%0d expected en=1 var=40 level=4", en, variable, level);
        end
        tick();
        tick();                       // second token issued, level 3
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (en !== 1'b0 || variable !== 7'h00 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL arst_async: got en=%b var=%h level=%0d expected en=0 var=00 level=0", en, variable, level);
        end
        tick();
        tick();
        rst = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (en !== 1'b0) extra++;
        end
        tests_run++;
        if (extra != 0 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL arst_after: got %0d pulses level=%0d expected 0 pulses level=0", extra, level);
        end
        in_valid = 1'b1;
        in_data = 7'h00;
        tick();
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (en !== 1'b1 || variable !== 7'h00 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL arst_newpush: got en=%b var=%h level=%0d expected en=1 var=00 level=0", en, variable, level);
        end
        req = 1'b0;
        tick();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_fill_wrap();
        test_stream();
        test_req_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
